uart_rx_fifo_v2: RTL and testbench

UART_RX_FIFO_V2 -- requirements
Module: uart_rx_fifo_v2

---
 rtl/uart_rx_fifo_v2.sv | 111 +++++++++++
 tb/tb_uart_rx_fifo_v2.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_v2.sv
// rtl/uart_rx_fifo_v2.sv - UART receive FIFO with per-character error flags and level/timeout interrupts
module uart_rx_fifo_v2 #(
  parameter int DATA_W = 8,
  parameter int FLAG_W = 3,
  parameter int DEPTH  = 16,
  parameter int TOUT_W = 10,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [DATA_W+FLAG_W-1:0] wr_data,
  input  logic                     rd_en,
  output logic [DATA_W+FLAG_W-1:0] rd_data,
  output logic [CNT_W-1:0]         count,
  output logic                     overrun,
  input  logic                     overrun_clr,
  output logic [CNT_W-1:0]         err_count,
  output logic                     err_present,
  input  logic [CNT_W-1:0]         threshold,
  output logic                     level_irq,
  input  logic [TOUT_W-1:0]        timeout_limit,
  output logic                     timeout_irq
);

  localparam int W  = DATA_W + FLAG_W;
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]      mem [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  err_q;
  logic [TOUT_W-1:0] idle_q;
  logic [TOUT_W-1:0] idle_nxt;
  logic              empty;
  logic              full;
  logic              push_ok;
  logic              pop_ok;
  logic              push_err;
  logic              pop_err;
  logic              ovr_set;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A full FIFO still accepts a write when a pop frees the head slot in the same cycle.
  assign push_ok  = wr_en & ~clear & (~full | (rd_en & ~empty));
  assign pop_ok   = rd_en & ~clear & ~empty;
  assign push_err = push_ok & (wr_data[FLAG_W-1:0] != '0);
  assign pop_err  = pop_ok & (mem[head][FLAG_W-1:0] != '0);
  assign ovr_set  = wr_en & ~rd_en & full & ~clear;

  always_comb begin
    idle_nxt = idle_q;
    if (empty | push_ok | pop_ok) begin
      idle_nxt = '0;
    end else if (idle_q != '1) begin
      idle_nxt = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst | clear) begin
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      err_q       <= '0;
      idle_q      <= '0;
      timeout_irq <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[tail] <= wr_data;
        tail      <= tail + 1'b1;
      end
      if (pop_ok) begin
        head <= head + 1'b1;
      end
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      err_q   <= err_q + CNT_W'(push_err) - CNT_W'(pop_err);
      idle_q  <= idle_nxt;
      // Raised on the same edge the idle counter reaches the limit, so it is visible alongside it.
      if (pop_ok | empty) begin
        timeout_irq <= 1'b0;
      end else if ((timeout_limit != '0) && (idle_nxt == timeout_limit)) begin
        timeout_irq <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst | clear) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  assign rd_data     = empty ? '0 : mem[head];
  assign count       = count_q;
  assign err_count   = err_q;
  assign err_present = (err_q != '0);
  assign level_irq   = (threshold != '0) & (count_q >= threshold);

endmodule

// File: tb/tb_uart_rx_fifo_v2.sv
// tb/tb_uart_rx_fifo_v2.sv - randomized and directed self-checking bench for uart_rx_fifo_v2
module tb_uart_rx_fifo_v2;

  localparam int DATA_W = 8;
  localparam int FLAG_W = 3;
  localparam int DEPTH  = 16;
  localparam int TOUT_W = 10;
  localparam int CNT_W  = 5;
  localparam int W      = DATA_W + FLAG_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              wr_en;
  logic [W-1:0]      wr_data;
  logic              rd_en;
  logic [W-1:0]      rd_data;
  logic [CNT_W-1:0]  count;
  logic              overrun;
  logic              overrun_clr;
  logic [CNT_W-1:0]  err_count;
  logic              err_present;
  logic [CNT_W-1:0]  threshold;
  logic              level_irq;
  logic [TOUT_W-1:0] timeout_limit;
  logic              timeout_irq;

  uart_rx_fifo_v2 #(
    .DATA_W(DATA_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH), .TOUT_W(TOUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .count(count), .overrun(overrun),
    .overrun_clr(overrun_clr), .err_count(err_count), .err_present(err_present),
    .threshold(threshold), .level_irq(level_irq), .timeout_limit(timeout_limit),
    .timeout_irq(timeout_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of stored characters plus sticky flags and an idle cycle count.
  logic [W-1:0] q[$];
  bit           m_ovr;
  bit           m_to;
  int           m_idle;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int  cnt;
    bit  push;
    bit  pop;
    if (rst || clear) begin
      q.delete();
      m_ovr  = 0;
      m_to   = 0;
      m_idle = 0;
    end else begin
      cnt  = q.size();
      push = wr_en && (cnt < DEPTH || (rd_en && cnt > 0));
      pop  = rd_en && cnt > 0;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(wr_data);
      if (wr_en && !rd_en && cnt == DEPTH) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
      if (cnt == 0 || push || pop) m_idle = 0;
      else if (m_idle < (1 << TOUT_W) - 1) m_idle++;
      if (pop || cnt == 0) m_to = 0;
      else if (timeout_limit != 0 && m_idle == int'(timeout_limit)) m_to = 1;
    end
  endtask

  task automatic check_all();
    int           errs;
    logic [W-1:0] hd;
    errs = 0;
    foreach (q[i]) if (q[i][FLAG_W-1:0] != 0) errs++;
    hd = (q.size() != 0) ? q[0] : '0;
    chk("count", 32'(count), 32'(q.size()));
    chk("rd_data", 32'(rd_data), 32'(hd));
    chk("err_count", 32'(err_count), 32'(errs));
    chk("err_present", 32'(err_present), 32'(errs != 0));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("level_irq", 32'(level_irq), 32'(threshold != 0 && q.size() >= int'(threshold)));
    chk("timeout_irq", 32'(timeout_irq), 32'(m_to));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic c, input logic w, input logic [W-1:0] d,
                       input logic rd, input logic oc);
    rst = r; clear = c; wr_en = w; wr_data = d; rd_en = rd; overrun_clr = oc;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] d;
    threshold = '0;
    timeout_limit = '0;
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);

    // three characters, the middle one flagged
    drive(1'b0, 1'b0, 1'b1, {8'h41, 3'b000}, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, {8'h42, 3'b100}, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, {8'h43, 3'b000}, 1'b0, 1'b0); tick();
    chk("seq_count", 32'(count), 32'd3);
    chk("seq_err", 32'(err_count), 32'd1);
    chk("seq_errp", 32'(err_present), 32'd1);
    chk("seq_head", 32'(rd_data), 32'({8'h41, 3'b000}));
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0); tick();
    chk("seq_pop1", 32'(rd_data), 32'({8'h42, 3'b100}));
    tick();
    chk("seq_pop2", 32'(rd_data), 32'({8'h43, 3'b000}));
    chk("seq_err0", 32'(err_count), 32'd0);
    tick();
    chk("seq_empty", 32'(count), 32'd0);

    // fill, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 1'b1, W'(i * 8 + 8), 1'b0, 1'b0); tick();
    end
    drive(1'b0, 1'b0, 1'b1, {8'hFF, 3'b000}, 1'b0, 1'b0); tick();
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(count), 32'd16);
    chk("ovr_head", 32'(rd_data), 32'd8);
    drive(1'b0, 1'b0, 1'b1, {8'hFE, 3'b000}, 1'b0, 1'b1); tick();
    chk("ovr_prio", 32'(overrun), 32'd1);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1); tick();
    chk("ovr_clr", 32'(overrun), 32'd0);

    // full FIFO streaming through a pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, W'($urandom), 1'b1, 1'b0); tick();
    end
    chk("stream_count", 32'(count), 32'd16);
    chk("stream_ovr", 32'(overrun), 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) tick();

    // level interrupt
    threshold = 5'd4;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, W'(100 + i), 1'b0, 1'b0); tick();
    end
    chk("lvl_3", 32'(level_irq), 32'd0);
    drive(1'b0, 1'b0, 1'b1, W'(200), 1'b0, 1'b0); tick();
    chk("lvl_4", 32'(level_irq), 32'd1);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0); tick();
    chk("lvl_pop", 32'(level_irq), 32'd0);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0); tick();
    threshold = '0;

    // character timeout
    timeout_limit = 10'd5;
    drive(1'b0, 1'b0, 1'b1, {8'h61, 3'b000}, 1'b0, 1'b0); tick();
    idle_in();
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("tout_wait", 32'(timeout_irq), 32'(k >= 5));
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0); tick();
    chk("tout_pop", 32'(timeout_irq), 32'd0);
    timeout_limit = '0;

    // read and write on an empty FIFO, then clear with a write
    drive(1'b0, 1'b0, 1'b1, {8'h55, 3'b000}, 1'b1, 1'b0); tick();
    chk("rw_empty_cnt", 32'(count), 32'd1);
    chk("rw_empty_data", 32'(rd_data), 32'({8'h55, 3'b000}));
    drive(1'b0, 1'b1, 1'b1, {8'h66, 3'b000}, 1'b0, 1'b0); tick();
    chk("clr_cnt", 32'(count), 32'd0);
    chk("clr_ovr", 32'(overrun), 32'd0);

    // reset in mid-operation
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, {8'(i + 1), 3'b010}, 1'b0, 1'b0); tick();
    end
    drive(1'b1, 1'b0, 1'b1, {8'h77, 3'b001}, 1'b1, 1'b0); tick();
    chk("mid_rst_cnt", 32'(count), 32'd0);
    chk("mid_rst_err", 32'(err_present), 32'd0);

    // randomized phase with alternating fill/drain bias
    for (int c = 0; c < 4000; c++) begin
      int wp;
      wp = ((c / 150) % 2 == 0) ? 75 : 30;
      if ($urandom_range(0, 99) < 3) threshold = CNT_W'($urandom_range(0, DEPTH));
      if ($urandom_range(0, 99) < 3) timeout_limit = TOUT_W'($urandom_range(0, 12));
      d = {8'($urandom), ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000};
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0,
            $urandom_range(0, 99) < wp, d, $urandom_range(0, 99) < (100 - wp),
            $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) < 3) begin
        wr_en = 1'b0;
        rd_en = 1'b0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
